his_peak_finder: RTL

Downstream stage of the histogram builder. On each completed acquisition pulse it sweeps the just-finished histogram bank pixel by pixel through a 1-cycle-latency read port. For every pixel it finds the peak bin (maximum count, lowest index on ties) and emits one result per pixel over a valid/ready handshake, where a threshold flags the result as hit or no-hit. The builder ping-pongs banks, so the finder reads one bank while the builder fills the other.

---
 rtl/his_peak_finder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/his_peak_finder.sv
// Peak-bin finder: sweeps one finished histogram bank pixel by pixel and
// reports the highest bin (lowest index on ties) per pixel over valid/ready.
module his_peak_finder #(
  parameter int NB      = 16,
  parameter int BIN_W   = 4,
  parameter int CNT_W   = 8,
  parameter int PIX_NUM = 4,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic              bank,
  input  logic [CNT_W-1:0]  thr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [CNT_W-1:0]  rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_pix,
  output logic [BIN_W-1:0]  out_bin,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_hit,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [2:0] {IDLE, READ, FLUSH, OUT, DONE} state_t;

  localparam logic [ADDR_W-1:0] BANK_SZ  = ADDR_W'(PIX_NUM * NB);
  localparam logic [ADDR_W-1:0] PIX_SZ   = ADDR_W'(NB);
  localparam logic [BIN_W-1:0]  LAST_BIN = BIN_W'(NB - 1);
  localparam logic [PIX_W-1:0]  LAST_PIX = PIX_W'(PIX_NUM - 1);

  state_t             state;
  logic               bank_q;
  logic [CNT_W-1:0]   thr_q;
  logic [PIX_W-1:0]   pix;
  logic [BIN_W-1:0]   bin;
  logic [CNT_W-1:0]   max_cnt, nx_cnt;
  logic [BIN_W-1:0]   max_bin, nx_bin;
  logic               cmp_vld;
  logic [BIN_W-1:0]   cmp_bin;

  function automatic logic [ADDR_W-1:0] addr_of(input logic b,
                                                 input logic [PIX_W-1:0] p,
                                                 input logic [BIN_W-1:0] n);
    return (b ? BANK_SZ : '0) + ADDR_W'(p) * PIX_SZ + ADDR_W'(n);
  endfunction

  // Bin 0 reloads the running max so a previous pixel's peak never leaks in.
  always_comb begin
    nx_cnt = max_cnt;
    nx_bin = max_bin;
    if (cmp_vld && (cmp_bin == '0 || rd_data > max_cnt)) begin
      nx_cnt = rd_data;
      nx_bin = cmp_bin;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      bank_q    <= 1'b0;
      thr_q     <= '0;
      pix       <= '0;
      bin       <= '0;
      max_cnt   <= '0;
      max_bin   <= '0;
      cmp_vld   <= 1'b0;
      cmp_bin   <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_bin   <= '0;
      out_cnt   <= '0;
      out_hit   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= start && (state != IDLE);
      cmp_vld <= rd_en;
      cmp_bin <= bin;
      max_cnt <= nx_cnt;
      max_bin <= nx_bin;
      case (state)
        IDLE: if (start) begin
          bank_q  <= bank;
          thr_q   <= thr;
          pix     <= '0;
          bin     <= '0;
          max_cnt <= '0;
          max_bin <= '0;
          rd_en   <= 1'b1;
          rd_addr <= addr_of(bank, '0, '0);
          busy    <= 1'b1;
          state   <= READ;
        end
        READ: begin
          if (bin == LAST_BIN) begin
            rd_en <= 1'b0;
            state <= FLUSH;
          end else begin
            bin     <= bin + 1'b1;
            rd_addr <= addr_of(bank_q, pix, bin + 1'b1);
          end
        end
        // The last read's data lands here; publish the merged result directly.
        FLUSH: begin
          out_valid <= 1'b1;
          out_pix   <= pix;
          out_bin   <= nx_bin;
          out_cnt   <= nx_cnt;
          out_hit   <= (nx_cnt >= thr_q);
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          if (pix == LAST_PIX) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            pix     <= pix + 1'b1;
            bin     <= '0;
            rd_en   <= 1'b1;
            rd_addr <= addr_of(bank_q, pix + 1'b1, '0);
            state   <= READ;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
